// File: rtl/mem_stage_ctrl_if.sv
// rtl/mem_stage_ctrl_if.sv - upstream and data-memory signal bundle for mem_stage_ctrl
//
// Purpose: groups the instruction handshake, the req/ack data-memory port and
// the result/status outputs of the Y86-64 memory-stage controller.
// Ports (signals):
//   start, icode, valE, valA, valP      upstream transaction request
//   mem_req, mem_we, mem_addr, mem_wdata request to data memory
//   mem_ack, mem_rdata                  data memory completion
//   valM, done, busy, dmem_error        result and status back upstream
// Modports: master = environment (pipeline + memory), slave = controller.
interface mem_stage_ctrl_if;
  logic        start;
  logic [3:0]  icode;
  logic [63:0] valE;
  logic [63:0] valA;
  logic [63:0] valP;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic [63:0] valM;
  logic        done;
  logic        busy;
  logic        dmem_error;

  modport master (
    output start, icode, valE, valA, valP, mem_ack, mem_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, valM, done, busy, dmem_error
  );

  modport slave (
    input  start, icode, valE, valA, valP, mem_ack, mem_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, valM, done, busy, dmem_error
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - Y86-64 memory-stage controller with req/ack data-memory port
//
// Purpose: takes one decoded instruction per transaction, decides whether it
// reads or writes data memory, bounds-checks the address, runs the req/ack
// handshake with a timeout, and returns valM / dmem_error with a done pulse.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mem_stage_ctrl_if.slave (see interface file for signal list)
module mem_stage_ctrl #(
  parameter int MEM_BYTES = 8192,
  parameter int TIMEOUT   = 16
) (
  input logic             clk,
  input logic             rst_n,
  mem_stage_ctrl_if.slave bus
);

  localparam int              CW       = $clog2(TIMEOUT + 1);
  localparam logic [63:0]     LAST_OK  = 64'(MEM_BYTES - 8);
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_REQ, S_FIN} state_t;

  state_t          r_state;
  logic            r_access;
  logic            r_we;
  logic [63:0]     r_addr;
  logic [63:0]     r_wdata;
  logic [63:0]     r_valm;
  logic            r_req;
  logic            r_done;
  logic            r_busy;
  logic            r_err;
  logic [CW-1:0]   r_wait;

  logic            w_is_wr;
  logic            w_is_rd;
  logic [63:0]     w_addr;
  logic [63:0]     w_wdata;

  // Decode of the incoming instruction; only used on the accepting cycle.
  always_comb begin
    w_is_wr = 1'b0;
    w_is_rd = 1'b0;
    case (bus.icode)
      4'd4, 4'd8, 4'd10: w_is_wr = 1'b1;
      4'd5, 4'd9, 4'd11: w_is_rd = 1'b1;
      default: ;
    endcase
    // ret/popq address the stack through valA; everything else uses valE.
    w_addr  = (bus.icode == 4'd9 || bus.icode == 4'd11) ? bus.valA : bus.valE;
    // call pushes the return address.
    w_wdata = (bus.icode == 4'd8) ? bus.valP : bus.valA;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_access <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_valm   <= '0;
      r_req    <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
      r_wait   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_access <= w_is_wr | w_is_rd;
            r_we     <= w_is_wr;
            r_addr   <= w_addr;
            r_wdata  <= w_wdata;
            r_busy   <= 1'b1;
            r_state  <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (!r_access) begin
            r_err   <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_FIN;
          end else if (r_addr > LAST_OK) begin
            // Unsigned compare also rejects negative signed addresses.
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_FIN;
          end else begin
            r_err   <= 1'b0;
            r_req   <= 1'b1;
            r_wait  <= '0;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          // Ack is tested before the timeout so a last-cycle ack still succeeds.
          if (bus.mem_ack) begin
            r_req   <= 1'b0;
            if (!r_we) r_valm <= bus.mem_rdata;
            r_done  <= 1'b1;
            r_state <= S_FIN;
          end else if (r_wait == CNT_LAST) begin
            r_req   <= 1'b0;
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_FIN;
          end else begin
            r_wait  <= r_wait + 1'b1;
          end
        end
        S_FIN: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_req    = r_req;
  assign bus.mem_we     = r_we;
  assign bus.mem_addr   = r_addr;
  assign bus.mem_wdata  = r_wdata;
  assign bus.valM       = r_valm;
  assign bus.done       = r_done;
  assign bus.busy       = r_busy;
  assign bus.dmem_error = r_err;

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Sequential controller for the Y86-64 memory stage.
- Accepts one decoded instruction per transaction: icode, valE, valA, valP.
- Decides whether the instruction touches data memory and drives a single-port req/ack data-memory interface.
- Returns valM, or signals dmem_error, with a done pulse; busy stalls upstream stages.

Parameters:
- MEM_BYTES, 8192: data memory size in bytes; legal 8-byte access needs addr <= MEM_BYTES-8 (unsigned).
- TIMEOUT, 16: maximum cycles to wait for mem_ack before flagging an error.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  transaction valid; sampled only in IDLE
- icode  in  4  Y86 instruction code
- valE  in  64  ALU result (signed)
- valA  in  64  register operand A (signed)
- valP  in  64  next PC (signed)
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  1 = write, 0 = read; valid while mem_req
- mem_addr  out  64  byte address; valid while mem_req
- mem_wdata  out  64  write data; valid while mem_req && mem_we
- mem_ack  in  1  memory completes the access this cycle
- mem_rdata  in  64  read data; valid with mem_ack
- valM  out  64  registered read result
- done  out  1  one-cycle completion pulse
- busy  out  1  high in any state other than IDLE
- dmem_error  out  1  registered error flag for the last transaction

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state = IDLE.
  - mem_req, mem_we, done, busy, dmem_error = 0.
  - mem_addr, mem_wdata, valM = 0.
  - Reset asserted mid-request drops mem_req immediately. A later mem_ack is ignored.
- Decode, latched on the cycle start is accepted:
  - icode 4 (rmmovq): write, addr = valE, data = valA.
  - icode 8 (call): write, addr = valE, data = valP.
  - icode 10 (pushq): write, addr = valE, data = valA.
  - icode 5 (mrmovq): read, addr = valE.
  - icode 9 (ret): read, addr = valA.
  - icode 11 (popq): read, addr = valA.
  - All other icodes (0-3, 6, 7, 12-15): no access.
- States: IDLE, CHECK, REQ, FIN.
- IDLE:
  - start=1 latches the inputs, then goes to CHECK.
  - start=0 stays in IDLE.
- CHECK, one cycle:
  - No-access icode: go to FIN, dmem_error = 0, valM unchanged.
  - Address unsigned > MEM_BYTES-8 (negative signed values included): go to FIN with dmem_error = 1. No request is issued.
  - Otherwise: go to REQ and set dmem_error = 0.
- REQ:
  - mem_req = 1 with mem_we/mem_addr/mem_wdata stable for the whole state.
  - A wait counter starts at 0 on entry and increments each cycle without ack.
  - mem_ack=1: leave for FIN. On reads, valM <= mem_rdata on that edge. Writes leave valM unchanged.
  - Counter reaches TIMEOUT-1 with no ack: go to FIN with dmem_error = 1, mem_req dropped, valM unchanged.
  - An ack arriving in the same cycle the counter reaches TIMEOUT-1 wins: success, no error.
- FIN: done = 1 for exactly one cycle, then IDLE.
- busy = 1 in CHECK, REQ and FIN. start is ignored whenever busy=1; no queuing.
- Latency from start to done:
  - No-access or bounds error: 2 cycles after start.
  - Memory access with ack in the first REQ cycle: 3 cycles after start.
  - Each extra wait cycle adds 1.
- Write data and address are 64-bit pass-through; no sign or width manipulation.
- mem_ack outside REQ is ignored.

Test Plan:
- Reset, then icode=1 (nop), start pulse -> done at start+2, mem_req never asserted, dmem_error=0, valM=0.
- icode=4, valE=16, valA=10, memory acks on the first REQ cycle -> mem_req=1, mem_we=1, mem_addr=16, mem_wdata=10 for 1 cycle; done at start+3.
- icode=5, valE=16, ack after 3 wait cycles with mem_rdata=10 -> address held stable for 4 cycles; valM=10 at done (start+6); dmem_error=0.
- icode=9, valA=MEM_BYTES-4 -> no mem_req; done at start+2 with dmem_error=1. Repeat with valA=-8 -> same result.
- icode=11, valA=24, mem_ack tied 0 -> mem_req high for exactly TIMEOUT cycles; then done with dmem_error=1 and valM unchanged. Next nop clears dmem_error.
- icode=8, valE=32, valP=100, start held high for 10 cycles, rst_n pulsed low during REQ -> mem_req drops immediately, busy=0, no done. After release, a fresh call completes with mem_wdata=100 and exactly one done.
